// File: rtl/vram_pkg.sv
// Shared VRAM bank definitions for the capture/display triple-buffer path.
// Latency: none (types, constants and a pure helper function only).
// Backpressure: not applicable.
package vram_pkg;

    typedef logic [1:0] vram_bank_t;

    localparam int NUM_VRAM_BANKS = 3;

    localparam vram_bank_t WR_BANK_RST   = 2'd0;
    localparam vram_bank_t RD_BANK_RST   = 2'd1;
    localparam vram_bank_t PEND_BANK_RST = 2'd2;

    // With banks {0,1,2}, the one bank not in {a,b} is (0+1+2) - a - b.
    // Only meaningful when a != b; 2-bit wraparound keeps the result in range.
    function automatic vram_bank_t free_bank(input vram_bank_t a, input vram_bank_t b);
        vram_bank_t sum_all;
        sum_all   = vram_bank_t'(NUM_VRAM_BANKS * (NUM_VRAM_BANKS - 1) / 2);
        free_bank = sum_all - a - b;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Synchronizes an asynchronous level into FCLK_CLK0 and emits a one-cycle rising-edge pulse.
// Latency: pulse appears SYNC_STAGES+1 cycles after the high level is first sampled.
// Backpressure: none; one pulse per high level, levels shorter than 2 cycles may be missed.
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic FCLK_CLK0,
    input  logic stop_n_rstb,
    input  logic async_in,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [1:0]             dly_q;
    logic                   pulse_q;

    // Metastability chain, a two-deep history of the settled level, and a registered edge pulse.
    always_ff @(posedge FCLK_CLK0 or negedge stop_n_rstb) begin
        if (!stop_n_rstb) begin
            sync_q  <= '0;
            dly_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], async_in};
            dly_q   <= {dly_q[0], sync_q[SYNC_STAGES-1]};
            pulse_q <= dly_q[0] & ~dly_q[1];
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/vram_frame_sel.sv
// Triple-buffer VRAM bank manager: picks the capture bank and the display bank; optional drop stats via VRAM_FRAME_SEL_STATS_EN.
// Latency: bank outputs and frame_done update 1 cycle after a synchronized vsync event; manual select 1 cycle.
// Backpressure: none; a frame that is incomplete or overwritten before display is dropped (and counted when stats are built in).
module vram_frame_sel
    import vram_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_WR_ACKS = 480,
    parameter int ACK_CNT_W   = 16
) (
    input  logic       FCLK_CLK0,
    input  logic       stop_n_rstb,
    input  logic       cap_vsync,
    input  logic       disp_vsync,
    input  logic       u_wack,
    input  logic       freeze,
    input  logic       manual_en,
    input  logic [1:0] in_vram_no,
    output logic [1:0] wr_vram_no,
    output logic [1:0] rd_vram_no,
    output logic       frame_done,
    output logic [7:0] drop_cnt
);

    localparam logic [ACK_CNT_W-1:0] MIN_ACKS_C = ACK_CNT_W'(MIN_WR_ACKS);

    logic cap_ev;
    logic disp_ev;

    vram_bank_t w_q, r_q, p_q, rd_q;
    vram_bank_t w_n, r_n, p_n, rd_n;
    logic       pv_q, pv_n;
    logic       frame_done_q;
    logic       frame_ok;

    logic [ACK_CNT_W-1:0] acks_q, acks_n;

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cap_sync (
        .FCLK_CLK0  (FCLK_CLK0),
        .stop_n_rstb(stop_n_rstb),
        .async_in   (cap_vsync),
        .pulse      (cap_ev)
    );

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_disp_sync (
        .FCLK_CLK0  (FCLK_CLK0),
        .stop_n_rstb(stop_n_rstb),
        .async_in   (disp_vsync),
        .pulse      (disp_ev)
    );

    // A frame is complete if enough line writes were acknowledged before its closing vsync.
    assign frame_ok = cap_ev && (acks_q >= MIN_ACKS_C);

    // Per-frame ack counter: restarts at each capture vsync (a coincident ack belongs to the new frame), saturates.
    always_comb begin
        acks_n = acks_q;
        if (cap_ev) begin
            acks_n = {{(ACK_CNT_W-1){1'b0}}, u_wack};
        end else if (u_wack && (acks_q != '1)) begin
            acks_n = acks_q + 1'b1;
        end
    end

    // Bank rotation: capture publish first, then display swap, so a coincident pair hands the new frame straight to R.
    always_comb begin
        w_n  = w_q;
        r_n  = r_q;
        p_n  = p_q;
        pv_n = pv_q;
        if (frame_ok) begin
            p_n  = w_q;
            w_n  = free_bank(r_q, w_q);
            pv_n = 1'b1;
        end
        if (disp_ev && pv_n && !freeze) begin
            r_n  = p_n;
            pv_n = 1'b0;
        end
        rd_n = manual_en ? in_vram_no : r_n;
    end

    // Bank state, ack counter and registered outputs.
    always_ff @(posedge FCLK_CLK0 or negedge stop_n_rstb) begin
        if (!stop_n_rstb) begin
            w_q          <= WR_BANK_RST;
            r_q          <= RD_BANK_RST;
            p_q          <= PEND_BANK_RST;
            pv_q         <= 1'b0;
            rd_q         <= RD_BANK_RST;
            acks_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            w_q          <= w_n;
            r_q          <= r_n;
            p_q          <= p_n;
            pv_q         <= pv_n;
            rd_q         <= rd_n;
            acks_q       <= acks_n;
            frame_done_q <= frame_ok;
        end
    end

    assign wr_vram_no = w_q;
    assign rd_vram_no = rd_q;
    assign frame_done = frame_done_q;

`ifdef VRAM_FRAME_SEL_STATS_EN
    logic       drop_inc;
    logic [7:0] drop_q;

    // A frame is lost when it closes incomplete, or when a complete one overwrites an undisplayed pending frame.
    assign drop_inc = cap_ev && (!frame_ok || pv_q);

    // Saturating drop counter, holds at 255.
    always_ff @(posedge FCLK_CLK0 or negedge stop_n_rstb) begin
        if (!stop_n_rstb) begin
            drop_q <= '0;
        end else if (drop_inc && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = '0;
`endif

`ifndef SYNTHESIS
    // Write and read banks must never collide, and a pending bank must be distinct from both.
    always @(posedge FCLK_CLK0) begin
        if (stop_n_rstb) begin
            assert (w_q != r_q && w_q < 2'd3 && r_q < 2'd3)
                else $error("bank collision W=%0d R=%0d", w_q, r_q);
            assert (!pv_q || (p_q != w_q && p_q != r_q && p_q < 2'd3))
                else $error("pending bank collision P=%0d W=%0d R=%0d", p_q, w_q, r_q);
        end
    end
`endif

endmodule

// File: tb/tb_vram_frame_sel.sv
// Directed bench for vram_frame_sel: bank rotation, drops, freeze, manual select, async reset.
// Latency: inputs driven and outputs sampled 1 time unit after each rising FCLK_CLK0 edge.
// Backpressure: not applicable.
module tb_vram_frame_sel;

`ifdef VRAM_FRAME_SEL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic       FCLK_CLK0;
    logic       stop_n_rstb;
    logic       cap_vsync;
    logic       disp_vsync;
    logic       u_wack;
    logic       freeze;
    logic       manual_en;
    logic [1:0] in_vram_no;
    logic [1:0] wr_vram_no;
    logic [1:0] rd_vram_no;
    logic       frame_done;
    logic [7:0] drop_cnt;

    int nchk  = 0;
    int nfail = 0;
    int fd_seen;

    vram_frame_sel #(
        .SYNC_STAGES(2),
        .MIN_WR_ACKS(480),
        .ACK_CNT_W  (16)
    ) dut (
        .FCLK_CLK0  (FCLK_CLK0),
        .stop_n_rstb(stop_n_rstb),
        .cap_vsync  (cap_vsync),
        .disp_vsync (disp_vsync),
        .u_wack     (u_wack),
        .freeze     (freeze),
        .manual_en  (manual_en),
        .in_vram_no (in_vram_no),
        .wr_vram_no (wr_vram_no),
        .rd_vram_no (rd_vram_no),
        .frame_done (frame_done),
        .drop_cnt   (drop_cnt)
    );

    initial FCLK_CLK0 = 1'b0;
    always #5 FCLK_CLK0 = ~FCLK_CLK0;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge FCLK_CLK0);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nchk++;
        assert (obs === exp)
            else begin
                nfail++;
                $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
            end
    endtask

    // Expected drop count: the counter only exists in the stats build.
    function automatic logic [7:0] xd(input int n);
        return STATS ? 8'(n) : 8'd0;
    endfunction

    task automatic wacks(input int n);
        u_wack = 1'b1;
        tick(n);
        u_wack = 1'b0;
    endtask

    // Hold the chosen vsync(s) high 8 cycles, low 4, counting frame_done pulses.
    task automatic vpulse(input bit c, input bit d);
        fd_seen    = 0;
        cap_vsync  = c;
        disp_vsync = d;
        repeat (8) begin
            tick(1);
            fd_seen += int'(frame_done);
        end
        cap_vsync  = 1'b0;
        disp_vsync = 1'b0;
        repeat (4) begin
            tick(1);
            fd_seen += int'(frame_done);
        end
    endtask

    initial begin
        stop_n_rstb = 1'b0;
        cap_vsync   = 1'b0;
        disp_vsync  = 1'b0;
        u_wack      = 1'b0;
        freeze      = 1'b0;
        manual_en   = 1'b0;
        in_vram_no  = 2'd0;
        tick(3);

        // Reset state (still in reset)
        check("rst_wr", 8'(wr_vram_no), 8'd0);
        check("rst_rd", 8'(rd_vram_no), 8'd1);
        check("rst_fd", 8'(frame_done), 8'd0);
        check("rst_drop", drop_cnt, 8'd0);
        stop_n_rstb = 1'b1;
        tick(2);

        // First complete frame; check event + output latency exactly
        wacks(480);
        cap_vsync = 1'b1;
        fd_seen   = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            fd_seen += int'(frame_done);
            if (i == 3) check("cap_lat_early", 8'(wr_vram_no), 8'd0);
            if (i == 4) check("cap_lat", 8'(wr_vram_no), 8'd2);
        end
        cap_vsync = 1'b0;
        repeat (4) begin
            tick(1);
            fd_seen += int'(frame_done);
        end
        check("f1_fd_once", 8'(fd_seen), 8'd1);
        check("f1_rd_held", 8'(rd_vram_no), 8'd1);
        check("f1_drop", drop_cnt, 8'd0);
        vpulse(1'b0, 1'b1);
        check("f1_disp_rd", 8'(rd_vram_no), 8'd0);
        check("f1_disp_wr", 8'(wr_vram_no), 8'd2);

        // Short frame (479 acks): dropped, banks unchanged. State W=2 R=0
        wacks(479);
        vpulse(1'b1, 1'b0);
        check("short_wr", 8'(wr_vram_no), 8'd2);
        check("short_rd", 8'(rd_vram_no), 8'd0);
        check("short_fd", 8'(fd_seen), 8'd0);
        check("short_drop", drop_cnt, xd(1));

        // Two complete frames, no display swap in between
        wacks(480);
        vpulse(1'b1, 1'b0);
        check("dbl1_wr", 8'(wr_vram_no), 8'd1);
        wacks(480);
        vpulse(1'b1, 1'b0);
        check("dbl2_wr", 8'(wr_vram_no), 8'd2);
        check("dbl2_drop", drop_cnt, xd(2));
        check("dbl2_rd_held", 8'(rd_vram_no), 8'd0);
        vpulse(1'b0, 1'b1);
        check("dbl_disp_rd", 8'(rd_vram_no), 8'd1);
        check("dbl_distinct", 8'(wr_vram_no != rd_vram_no), 8'd1);

        // Fresh reset, then capture and display vsync together
        stop_n_rstb = 1'b0;
        tick(2);
        stop_n_rstb = 1'b1;
        tick(2);
        check("rst2_drop", drop_cnt, 8'd0);
        wacks(480);
        vpulse(1'b1, 1'b1);
        check("same_rd", 8'(rd_vram_no), 8'd0);
        check("same_wr", 8'(wr_vram_no), 8'd2);
        check("same_fd", 8'(fd_seen), 8'd1);
        vpulse(1'b0, 1'b1);
        check("same_nopend_rd", 8'(rd_vram_no), 8'd0);

        // Freeze across three complete frames. State W=2 R=0
        freeze = 1'b1;
        wacks(480);
        vpulse(1'b1, 1'b0);
        check("frz1_wr", 8'(wr_vram_no), 8'd1);
        vpulse(1'b0, 1'b1);
        check("frz_disp_ignored", 8'(rd_vram_no), 8'd0);
        wacks(480);
        vpulse(1'b1, 1'b0);
        check("frz2_wr", 8'(wr_vram_no), 8'd2);
        wacks(480);
        vpulse(1'b1, 1'b0);
        check("frz3_wr", 8'(wr_vram_no), 8'd1);
        check("frz3_rd", 8'(rd_vram_no), 8'd0);
        check("frz3_drop", drop_cnt, xd(2));
        freeze = 1'b0;
        vpulse(1'b0, 1'b1);
        check("unfrz_rd", 8'(rd_vram_no), 8'd2);

        // Manual display bank select. State W=1 R=2
        in_vram_no = 2'd0;
        manual_en  = 1'b1;
        tick(1);
        check("man_0", 8'(rd_vram_no), 8'd0);
        in_vram_no = 2'd2;
        tick(1);
        check("man_2", 8'(rd_vram_no), 8'd2);
        in_vram_no = 2'd0;
        tick(1);
        check("man_back0", 8'(rd_vram_no), 8'd0);
        manual_en = 1'b0;
        tick(1);
        check("man_off", 8'(rd_vram_no), 8'd2);

        // Asynchronous reset mid-frame with a vsync in flight
        wacks(200);
        cap_vsync = 1'b1;
        tick(2);
        stop_n_rstb = 1'b0;
        #1;
        check("arst_wr", 8'(wr_vram_no), 8'd0);
        check("arst_rd", 8'(rd_vram_no), 8'd1);
        check("arst_fd", 8'(frame_done), 8'd0);
        check("arst_drop", drop_cnt, 8'd0);
        cap_vsync = 1'b0;
        tick(3);
        stop_n_rstb = 1'b1;
        tick(2);
        check("post_rst_wr", 8'(wr_vram_no), 8'd0);

        // Ack count must have been cleared: an ack-less frame is a drop
        vpulse(1'b1, 1'b0);
        check("post_rst_cap_wr", 8'(wr_vram_no), 8'd0);
        check("post_rst_cap_fd", 8'(fd_seen), 8'd0);
        check("post_rst_cap_drop", drop_cnt, xd(1));

        $display("[TB] %0d tests run, %0d failed", nchk, nfail);
        $finish;
    end

endmodule
